// File: rtl/loc_update_unit.sv
// Location-update datapath for the maze-mouse controller.
// Holds the current {X,Y} location in two 4-bit registers and forms the next
// location from a +/-1 step on one axis, a popped stack location, or zero.
// Leaf modules (adder, mux2To1, reg4B) are usable on their own.

// ---------------------------------------------------------------------------
// adder: 4-bit enabled adder. When disabled both sum and carry read as zero.
// ---------------------------------------------------------------------------
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       en,
    output logic [3:0] sum,
    output logic       co
);
    logic [4:0] full_sum;

    // Widen to five bits so the carry falls out of the addition directly
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        if (en) begin
            sum = full_sum[3:0];
            co  = full_sum[4];
        end else begin
            sum = 4'h0;
            co  = 1'b0;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// mux2To1: 8-bit two-input selector.
// ---------------------------------------------------------------------------
module mux2To1 (
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       sl,
    output logic [7:0] out
);
    // Plain select; in1 wins when sl is high
    always_comb begin
        out = sl ? in1 : in0;
    end
endmodule

// ---------------------------------------------------------------------------
// reg4B: 4-bit load register with asynchronous clear.
// ---------------------------------------------------------------------------
module reg4B (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] dataIn,
    output logic [3:0] dataOut
);
    // Clear immediately on rst, otherwise load on the edge when ld is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= 4'h0;
        end else if (ld) begin
            dataOut <= dataIn;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// loc_update_unit: top-level location datapath.
// ---------------------------------------------------------------------------
module loc_update_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       rgLd,
    input  logic [1:0] dir,
    input  logic       adderEn,
    input  logic       pop,
    input  logic [7:0] popedLoc,
    output logic [7:0] curLoc,
    output logic [7:0] nxtLoc,
    output logic       cntReach,
    output logic       co
);
    // dir: 00 Y-1, 01 X+1, 10 X-1, 11 Y+1.
    // The two X moves are the codes whose bits differ, so XOR picks the axis,
    // and bit 0 alone distinguishes increment from decrement.
    logic       axis_sel;
    logic [3:0] add_to;
    logic [3:0] to_add;
    logic [3:0] step_res;
    logic [3:0] reach_sum;
    logic [7:0] stepped_x;
    logic [7:0] stepped_y;
    logic [7:0] stepped_loc;
    logic [7:0] move_loc;
    logic [7:0] pop_loc;

    // Pick the nibble being moved and the +1 / -1 step value
    always_comb begin
        axis_sel = dir[1] ^ dir[0];
        add_to   = axis_sel ? curLoc[7:4] : curLoc[3:0];
        to_add   = dir[0] ? 4'h1 : 4'hF;
    end

    adder u_step_adder (
        .a   (add_to),
        .b   (to_add),
        .ci  (1'b0),
        .en  (adderEn),
        .sum (step_res),
        .co  (co)
    );

    // Boundary flag: the step would wrap (F on increment, 0 on decrement).
    // Computed regardless of adderEn so the FSM can test a move before issuing it.
    always_comb begin
        reach_sum = add_to + {3'b000, dir[0]};
        cntReach  = (reach_sum == 4'h0);
    end

    // Candidate locations with the stepped nibble spliced back in
    always_comb begin
        stepped_x = {step_res, curLoc[3:0]};
        stepped_y = {curLoc[7:4], step_res};
    end

    // Priority chain, lowest priority first: axis, step-vs-hold, pop, reset.
    // The hold path feeds back the registered curLoc, never nxtLoc itself.
    mux2To1 u_mux_axis (
        .in0 (stepped_y),
        .in1 (stepped_x),
        .sl  (axis_sel),
        .out (stepped_loc)
    );

    mux2To1 u_mux_step (
        .in0 (curLoc),
        .in1 (stepped_loc),
        .sl  (adderEn),
        .out (move_loc)
    );

    mux2To1 u_mux_pop (
        .in0 (move_loc),
        .in1 (popedLoc),
        .sl  (pop),
        .out (pop_loc)
    );

    mux2To1 u_mux_rst (
        .in0 (pop_loc),
        .in1 (8'h00),
        .sl  (rst),
        .out (nxtLoc)
    );

    // One register per axis: gi=0 holds Y (low nibble), gi=1 holds X
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            reg4B u_axis_reg (
                .clk     (clk),
                .rst     (rst),
                .ld      (rgLd),
                .dataIn  (nxtLoc[gi*4 +: 4]),
                .dataOut (curLoc[gi*4 +: 4])
            );
        end
    endgenerate
endmodule

// File: tb/tb_loc_update_unit.sv
// Self-checking bench for loc_update_unit and its leaf modules.
// A coordinate-level model (x/y integers, move table) predicts every output;
// a negedge process compares on every cycle, and directed steps pin literals.
`timescale 1ns/1ps
module tb_loc_update_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rgLd = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       adderEn = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] popedLoc = 8'h00;
    logic [7:0] curLoc;
    logic [7:0] nxtLoc;
    logic       cntReach;
    logic       co;

    // standalone leaf instances
    logic [3:0] la, lb, lsum;
    logic       lci, len, lco;
    logic [7:0] m_in0, m_in1, m_out;
    logic       m_sl;
    logic       r_rst, r_ld;
    logic [3:0] r_din, r_dout;

    int checks = 0;
    int failures = 0;
    logic       chk_en = 1'b0;
    logic [7:0] model_cur = 8'h00;

    loc_update_unit dut (
        .clk      (clk),
        .rst      (rst),
        .rgLd     (rgLd),
        .dir      (dir),
        .adderEn  (adderEn),
        .pop      (pop),
        .popedLoc (popedLoc),
        .curLoc   (curLoc),
        .nxtLoc   (nxtLoc),
        .cntReach (cntReach),
        .co       (co)
    );

    adder u_add (.a(la), .b(lb), .ci(lci), .en(len), .sum(lsum), .co(lco));
    mux2To1 u_mux (.in0(m_in0), .in1(m_in1), .sl(m_sl), .out(m_out));
    reg4B u_reg (.clk(clk), .rst(r_rst), .ld(r_ld), .dataIn(r_din), .dataOut(r_dout));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model, in coordinate terms ----
    function automatic bit is_x_move(input logic [1:0] d);
        return (d == 2'b01) || (d == 2'b10);
    endfunction

    function automatic bit is_inc(input logic [1:0] d);
        return (d == 2'b01) || (d == 2'b11);
    endfunction

    function automatic int coord(input logic [7:0] cur, input logic [1:0] d);
        return is_x_move(d) ? int'(cur[7:4]) : int'(cur[3:0]);
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic r, input logic p,
                                              input logic [7:0] pl, input logic ae, input logic [1:0] d);
        int x, y;
        logic [3:0] xn, yn;
        x = cur[7:4];
        y = cur[3:0];
        if (r) return 8'h00;
        if (p) return pl;
        if (!ae) return cur;
        case (d)
            2'b00: y = (y + 15) % 16;
            2'b01: x = (x + 1) % 16;
            2'b10: x = (x + 15) % 16;
            default: y = (y + 1) % 16;
        endcase
        xn = 4'(x);
        yn = 4'(y);
        return {xn, yn};
    endfunction

    function automatic logic model_reach(input logic [7:0] cur, input logic [1:0] d);
        return is_inc(d) ? (coord(cur, d) == 15) : (coord(cur, d) == 0);
    endfunction

    function automatic logic model_co(input logic [7:0] cur, input logic ae, input logic [1:0] d);
        if (!ae) return 1'b0;
        return is_inc(d) ? (coord(cur, d) == 15) : (coord(cur, d) != 0);
    endfunction

    // Model register: cleared asynchronously, otherwise loads on edges with rgLd
    always @(posedge clk or posedge rst) begin
        if (rst) model_cur = 8'h00;
        else if (rgLd) model_cur = model_next(model_cur, rst, pop, popedLoc, adderEn, dir);
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_curLoc", {24'h0, curLoc}, {24'h0, model_cur});
            chk("cyc_nxtLoc", {24'h0, nxtLoc}, {24'h0, model_next(model_cur, rst, pop, popedLoc, adderEn, dir)});
            chk("cyc_cntReach", {31'h0, cntReach}, {31'h0, model_reach(model_cur, dir)});
            chk("cyc_co", {31'h0, co}, {31'h0, model_co(model_cur, adderEn, dir)});
        end
    end

    // Location trace
    always @(curLoc) begin
        $display("Mouse Location --> X:%0d Y:%0d", curLoc[7:4], curLoc[3:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a location through the pop path
    task automatic load_loc(input logic [7:0] loc);
        rgLd = 1'b1; pop = 1'b1; popedLoc = loc; adderEn = 1'b0;
        step();
        pop = 1'b0;
    endtask

    initial begin
        // leaf defaults
        la = 4'h0; lb = 4'h0; lci = 1'b0; len = 1'b0;
        m_in0 = 8'h00; m_in1 = 8'h00; m_sl = 1'b0;
        r_rst = 1'b1; r_ld = 1'b0; r_din = 4'h0;

        // reset pulse between edges
        #1 rst = 1'b1;
        #1;
        chk("rst_curLoc", {24'h0, curLoc}, 32'h00);
        chk("rst_nxtLoc", {24'h0, nxtLoc}, 32'h00);
        step();
        rst = 1'b0;
        r_rst = 1'b0;
        chk_en = 1'b1;

        // hold with no step selected
        rgLd = 1'b1; adderEn = 1'b0; pop = 1'b0;
        step();
        chk("hold_zero", {24'h0, curLoc}, 32'h00);

        // walk a square
        adderEn = 1'b1;
        dir = 2'b01; step(); chk("walk_x_inc", {24'h0, curLoc}, 32'h10);
        dir = 2'b11; step(); chk("walk_y_inc", {24'h0, curLoc}, 32'h11);
        dir = 2'b00; step(); chk("walk_y_dec", {24'h0, curLoc}, 32'h10);
        dir = 2'b10; step(); chk("walk_x_dec", {24'h0, curLoc}, 32'h00);

        // boundary at X=F
        load_loc(8'hF3);
        rgLd = 1'b0; adderEn = 1'b1; dir = 2'b01;
        #1;
        chk("bnd_reach", {31'h0, cntReach}, 32'h1);
        chk("bnd_co", {31'h0, co}, 32'h1);
        chk("bnd_nxt", {24'h0, nxtLoc}, 32'h03);

        // boundary at origin for decrements
        load_loc(8'h00);
        rgLd = 1'b0; adderEn = 1'b1;
        dir = 2'b00; #1 chk("org_reach_ydec", {31'h0, cntReach}, 32'h1);
        dir = 2'b10; #1 chk("org_reach_xdec", {31'h0, cntReach}, 32'h1);
        dir = 2'b01; #1 chk("org_noreach_xinc", {31'h0, cntReach}, 32'h0);

        // pop beats the adder
        load_loc(8'h22);
        rgLd = 1'b1; adderEn = 1'b1; dir = 2'b01; pop = 1'b1; popedLoc = 8'h5A;
        step();
        chk("pop_prio", {24'h0, curLoc}, 32'h5A);
        pop = 1'b0;

        // load disabled holds location
        load_loc(8'h44);
        rgLd = 1'b0; adderEn = 1'b1; dir = 2'b11;
        repeat (3) step();
        chk("noload_cur", {24'h0, curLoc}, 32'h44);
        chk("noload_nxt", {24'h0, nxtLoc}, 32'h45);

        // reset mid-operation clears without a clock edge
        load_loc(8'h5A);
        rst = 1'b1;
        #1;
        chk("async_rst_cur", {24'h0, curLoc}, 32'h00);
        chk("async_rst_nxt", {24'h0, nxtLoc}, 32'h00);
        #1 rst = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rgLd     = ($urandom_range(0, 9) != 0);
            adderEn  = $urandom_range(0, 1);
            pop      = ($urandom_range(0, 7) == 0);
            popedLoc = 8'($urandom);
            dir      = 2'($urandom);
            rst      = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;
        step();
        chk_en = 1'b0;

        // leaf: adder
        la = 4'h7; lb = 4'h9; lci = 1'b1; len = 1'b1;
        #1;
        chk("adder_sum", {28'h0, lsum}, 32'h1);
        chk("adder_co", {31'h0, lco}, 32'h1);
        len = 1'b0;
        #1;
        chk("adder_dis_sum", {28'h0, lsum}, 32'h0);
        chk("adder_dis_co", {31'h0, lco}, 32'h0);

        // leaf: mux
        m_in0 = 8'hAA; m_in1 = 8'h55; m_sl = 1'b1;
        #1 chk("mux_sel1", {24'h0, m_out}, 32'h55);
        m_sl = 1'b0;
        #1 chk("mux_sel0", {24'h0, m_out}, 32'hAA);

        // leaf: reg4B load, hold, async clear
        r_ld = 1'b1; r_din = 4'h9;
        step();
        chk("reg_load", {28'h0, r_dout}, 32'h9);
        r_ld = 1'b0; r_din = 4'h3;
        step();
        chk("reg_hold", {28'h0, r_dout}, 32'h9);
        r_rst = 1'b1;
        #1 chk("reg_async_clr", {28'h0, r_dout}, 32'h0);
        r_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
